// File: rtl/sandbox_pkg.sv
// Shared definitions for the ESFA bridge: opcodes, FSM states, payload lane
// offsets and the status-byte packing helper.
package sandbox_pkg;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_QUERY   = 2'b01,
    OP_STATS   = 2'b10,
    OP_ILLEGAL = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RESPOND = 3'd3,
    ST_HOLD    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Host payload / response width.
  localparam int DATA_W = 56;

  // Request payload lanes (each field takes the low bits of its lane).
  localparam int INDEX_LSB  = 8;
  localparam int VALUE_LSB  = 16;
  localparam int META_LSB   = 24;
  localparam int ISMETA_BIT = 32;
  localparam int SELECT_LSB = 40;

  // Response payload lanes.
  localparam int RESP_VALUE_LSB = 8;
  localparam int RESP_QCNT_LSB  = 24;

  // Status byte: [7:4] sequence, [3:2] opcode, [1] last query hit, [0] illegal.
  function automatic logic [7:0] make_status(logic [3:0] seq, opcode_e op, logic hit);
    return {seq, op, hit, (op == OP_ILLEGAL)};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, used for bridge statistics.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] value
);

  // Count up on inc, stick at all-ones, clear wins over inc.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (clear) begin
      value <= '0;
    end else if (inc && (value != {WIDTH{1'b1}})) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/sandbox_esfa_bridge.sv
// Host-packet to ESFA bridge: decodes a host command, performs at most one
// ESFA access, returns a response packet and keeps saturating statistics.
module sandbox_esfa_bridge
  import sandbox_pkg::*;
#(
  parameter int KEY_W    = 8,
  parameter int VAL_W    = 8,
  parameter int ESFA_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              masterClock,
  input  logic              reset,
  input  logic              dataReceived,
  input  logic [7:0]        control,
  input  logic [DATA_W-1:0] inputData,
  output logic              clearDR,
  output logic              transmitData,
  output logic [7:0]        status,
  output logic [DATA_W-1:0] outputData,
  output logic              esfaValid,
  output logic              esfaWillWrite,
  output logic              esfaIsMetadata,
  output logic [KEY_W-1:0]  esfaIndex,
  output logic [KEY_W-1:0]  esfaMetadata,
  output logic [KEY_W-1:0]  esfaSelector,
  output logic [VAL_W-1:0]  esfaValue,
  input  logic              esfaResultBool,
  input  logic [VAL_W-1:0]  esfaResultValue
);

  localparam logic [3:0] LAT = 4'(ESFA_LAT);

  state_e              state;
  opcode_e             op;
  opcode_e             new_op;
  logic [3:0]          wait_cnt;
  logic [3:0]          seq;
  logic                hold_cnt;
  logic                last_hit;
  logic                wait_done;
  logic                write_inc;
  logic                query_inc;
  logic                hit_inc;
  logic [CNT_W-1:0]    write_count;
  logic [CNT_W-1:0]    query_count;
  logic [CNT_W-1:0]    hit_count;
  logic [DATA_W-1:0]   stats_payload;
  logic                unused_bits;

  assign new_op    = opcode_e'(control[1:0]);
  assign wait_done = (wait_cnt <= 4'd1);

  assign write_inc = (state == ST_ISSUE) && (op == OP_WRITE);
  assign query_inc = (state == ST_ISSUE) && (op == OP_QUERY);
  assign hit_inc   = (state == ST_WAIT) && wait_done && (op == OP_QUERY) && esfaResultBool;

  assign stats_payload = DATA_W'(write_count) | (DATA_W'(query_count) << RESP_QCNT_LSB);

  // Payload bits outside the decoded lanes and the hit statistic have no consumer here.
  assign unused_bits = ^{control[7:2], inputData, hit_count};

  sat_counter #(.WIDTH(CNT_W)) u_write_count (
    .clk   (masterClock),
    .inc   (write_inc),
    .clear (reset),
    .value (write_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_query_count (
    .clk   (masterClock),
    .inc   (query_inc),
    .clear (reset),
    .value (query_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_hit_count (
    .clk   (masterClock),
    .inc   (hit_inc),
    .clear (reset),
    .value (hit_count)
  );

  // Transaction FSM; every output is registered and loaded on state transitions.
  always_ff @(posedge masterClock) begin
    if (reset) begin
      state          <= ST_IDLE;
      op             <= OP_WRITE;
      wait_cnt       <= '0;
      seq            <= '0;
      hold_cnt       <= 1'b0;
      last_hit       <= 1'b0;
      clearDR        <= 1'b0;
      transmitData   <= 1'b0;
      status         <= '0;
      outputData     <= '0;
      esfaValid      <= 1'b0;
      esfaWillWrite  <= 1'b0;
      esfaIsMetadata <= 1'b0;
      esfaIndex      <= '0;
      esfaMetadata   <= '0;
      esfaSelector   <= '0;
      esfaValue      <= '0;
    end else begin
      esfaValid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dataReceived) begin
            op             <= new_op;
            esfaIndex      <= inputData[INDEX_LSB +: KEY_W];
            esfaValue      <= inputData[VALUE_LSB +: VAL_W];
            esfaMetadata   <= inputData[META_LSB +: KEY_W];
            esfaSelector   <= inputData[SELECT_LSB +: KEY_W];
            esfaIsMetadata <= inputData[ISMETA_BIT];
            esfaWillWrite  <= (new_op == OP_WRITE);
            if ((new_op == OP_WRITE) || (new_op == OP_QUERY)) begin
              esfaValid <= 1'b1;
              state     <= ST_ISSUE;
            end else begin
              // STATS and ILLEGAL answer straight away without touching the ESFA.
              transmitData <= 1'b1;
              seq          <= seq + 4'd1;
              status       <= make_status(seq + 4'd1, new_op, last_hit);
              outputData   <= (new_op == OP_STATS) ? stats_payload : '0;
              state        <= ST_RESPOND;
            end
          end
        end
        ST_ISSUE: begin
          wait_cnt <= LAT;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_done) begin
            transmitData <= 1'b1;
            seq          <= seq + 4'd1;
            if (op == OP_QUERY) begin
              last_hit   <= esfaResultBool;
              outputData <= DATA_W'(esfaResultBool)
                          | (DATA_W'(esfaResultValue) << RESP_VALUE_LSB);
              status     <= make_status(seq + 4'd1, op, esfaResultBool);
            end else begin
              outputData <= DATA_W'(1);
              status     <= make_status(seq + 4'd1, op, last_hit);
            end
            state <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          hold_cnt <= 1'b0;
          state    <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_cnt) begin
            clearDR <= 1'b1;
            state   <= ST_DONE;
          end else begin
            hold_cnt <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!dataReceived) begin
            transmitData <= 1'b0;
            clearDR      <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        // NOTE: unreachable encodings fall back to IDLE so a corrupted state self-recovers.
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sandbox_esfa_bridge.sv
// Self-checking bench for sandbox_esfa_bridge: directed and $urandom
// transactions against a transaction-level reference model, with a behavioural
// ESFA store that only returns true data exactly ESFA_LAT cycles after the strobe.
module tb_sandbox_esfa_bridge;

  localparam int KEY_W = 8;
  localparam int VAL_W = 8;
  localparam int LAT   = 3;
  localparam int CNT_W = 16;
  localparam int CNT_S = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        dr;
  logic [7:0]  ctrl;
  logic [55:0] din;
  logic        rbool;
  logic [7:0]  rval;

  logic        clr, tx, ev, ew, em;
  logic [7:0]  st, eidx, emeta, esel, evalue;
  logic [55:0] dout;

  logic        clr_s, tx_s, ev_s, ew_s, em_s;
  logic [7:0]  st_s, eidx_s, emeta_s, esel_s, evalue_s;
  logic [55:0] dout_s;

  always #5 clk = ~clk;

  sandbox_esfa_bridge #(.KEY_W(KEY_W), .VAL_W(VAL_W), .ESFA_LAT(LAT), .CNT_W(CNT_W)) dut (
    .masterClock(clk), .reset(rst), .dataReceived(dr), .control(ctrl), .inputData(din),
    .clearDR(clr), .transmitData(tx), .status(st), .outputData(dout),
    .esfaValid(ev), .esfaWillWrite(ew), .esfaIsMetadata(em),
    .esfaIndex(eidx), .esfaMetadata(emeta), .esfaSelector(esel), .esfaValue(evalue),
    .esfaResultBool(rbool), .esfaResultValue(rval)
  );

  // Narrow-counter twin so saturation is reachable within a short run.
  sandbox_esfa_bridge #(.KEY_W(KEY_W), .VAL_W(VAL_W), .ESFA_LAT(LAT), .CNT_W(CNT_S)) dut_s (
    .masterClock(clk), .reset(rst), .dataReceived(dr), .control(ctrl), .inputData(din),
    .clearDR(clr_s), .transmitData(tx_s), .status(st_s), .outputData(dout_s),
    .esfaValid(ev_s), .esfaWillWrite(ew_s), .esfaIsMetadata(em_s),
    .esfaIndex(eidx_s), .esfaMetadata(emeta_s), .esfaSelector(esel_s), .esfaValue(evalue_s),
    .esfaResultBool(rbool), .esfaResultValue(rval)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural ESFA store ----------------
  logic [7:0] mem_val [256];
  bit         mem_ok  [256];
  int         age = -1;
  logic [7:0] q_idx = '0;
  int         strobes = 0;
  logic [7:0] s_idx, s_val, s_meta, s_sel;
  logic       s_ism, s_ww;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_val[i] = '0;
      mem_ok[i]  = 1'b0;
    end
    rbool = 1'b0;
    rval  = '0;
  end

  always @(negedge clk) begin
    if (ev) begin
      strobes++;
      s_idx  = eidx;
      s_val  = evalue;
      s_meta = emeta;
      s_sel  = esel;
      s_ism  = em;
      s_ww   = ew;
      age    = 0;
      q_idx  = eidx;
      if (ew) begin
        mem_val[eidx] = evalue;
        mem_ok[eidx]  = 1'b1;
      end
    end else if (age >= 0 && age < 64) begin
      age++;
    end
    if (age == LAT) begin
      rbool = mem_ok[q_idx];
      rval  = mem_val[q_idx];
    end else begin
      rbool = ~mem_ok[q_idx];
      rval  = ~mem_val[q_idx];
    end
  end

  // ---------------- reference model ----------------
  int         wr_cnt = 0;
  int         q_cnt  = 0;
  int         seq    = 0;
  bit         last_hit = 1'b0;
  logic [7:0] ref_val [256];
  bit         ref_ok  [256];

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_val[i] = '0;
      ref_ok[i]  = 1'b0;
    end
  end

  function automatic logic [63:0] sat(input int v, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return (64'(v) > m) ? m : 64'(v);
  endfunction

  task automatic model_reset();
    wr_cnt   = 0;
    q_cnt    = 0;
    seq      = 0;
    last_hit = 1'b0;
  endtask

  // One complete host transaction with full response / handshake checking.
  task automatic run_txn(input logic [1:0] op, input logic [7:0] idx, input logic [7:0] val,
                         input logic [7:0] meta, input logic [7:0] sel, input logic ism,
                         input bit glitch, input bit hold_done);
    logic [63:0] exp, exp_s;
    logic [7:0]  exp_st;
    logic [3:0]  seq4;
    int          s0, k;

    exp   = '0;
    exp_s = '0;
    case (op)
      2'b00: begin
        wr_cnt++;
        ref_val[idx] = val;
        ref_ok[idx]  = 1'b1;
        exp   = 64'd1;
        exp_s = 64'd1;
      end
      2'b01: begin
        q_cnt++;
        last_hit = ref_ok[idx];
        exp   = 64'(ref_ok[idx]) | (64'(ref_val[idx]) << 8);
        exp_s = exp;
      end
      2'b10: begin
        exp   = sat(wr_cnt, CNT_W) | (sat(q_cnt, CNT_W) << 24);
        exp_s = sat(wr_cnt, CNT_S) | (sat(q_cnt, CNT_S) << 24);
      end
      default: begin
        exp   = '0;
        exp_s = '0;
      end
    endcase
    seq    = (seq + 1) % 16;
    seq4   = 4'(seq);
    exp_st = {seq4, op, last_hit, (op == 2'b11)};

    s0 = strobes;
    @(negedge clk);
    ctrl = {6'($urandom), op};
    din  = 56'({$urandom(), $urandom()});
    din[15:8]  = idx;
    din[23:16] = val;
    din[31:24] = meta;
    din[32]    = ism;
    din[47:40] = sel;
    dr = 1'b1;

    k = 0;
    while (!tx && k < 60) begin
      @(negedge clk);
      k++;
      if (glitch) begin
        if (k == 1) dr = 1'b0;
        else if (k == 2) begin dr = 1'b1; ctrl = 8'h03; end
        else if (k == 3) dr = 1'b0;
      end
    end
    check("tx_rise", 64'(tx), 64'd1);
    check("resp_latency", 64'(k), (op < 2'b10) ? 64'(LAT + 2) : 64'd1);
    check("out_data", 64'(dout), exp);
    check("status", 64'(st), 64'(exp_st));
    check("out_data_narrow", 64'(dout_s), exp_s);
    check("status_narrow", 64'(st_s), 64'(exp_st));
    check("strobe_count", 64'(strobes - s0), (op < 2'b10) ? 64'd1 : 64'd0);
    if (op < 2'b10) begin
      check("esfa_index", 64'(s_idx), 64'(idx));
      check("esfa_value", 64'(s_val), 64'(val));
      check("esfa_meta", 64'(s_meta), 64'(meta));
      check("esfa_sel", 64'(s_sel), 64'(sel));
      check("esfa_ismeta", 64'(s_ism), 64'(ism));
      check("esfa_willwrite", 64'(s_ww), (op == 2'b00) ? 64'd1 : 64'd0);
    end

    k = 0;
    while (!clr && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("clr_delay", 64'(k), 64'd3);

    if (hold_done) begin
      s0 = strobes;
      repeat (10) @(negedge clk);
      check("done_hold_tx", 64'(tx), 64'd1);
      check("done_hold_clr", 64'(clr), 64'd1);
      check("done_hold_no_strobe", 64'(strobes - s0), 64'd0);
    end

    dr = 1'b0;
    @(negedge clk);
    check("tx_clear", 64'(tx), 64'd0);
    check("clr_clear", 64'(clr), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx"},   64'(tx), 64'd0);
    check({tag, "_clr"},  64'(clr), 64'd0);
    check({tag, "_ev"},   64'(ev), 64'd0);
    check({tag, "_st"},   64'(st), 64'd0);
    check({tag, "_dout"}, 64'(dout), 64'd0);
    check({tag, "_fields"}, 64'({ew, em, eidx, emeta, esel, evalue}), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, k;
    rst  = 1'b1;
    dr   = 1'b0;
    ctrl = '0;
    din  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");

    // Directed: WRITE idx 3 = 0x5A, QUERY hit, ILLEGAL, STATS, glitched QUERY miss.
    run_txn(2'b00, 8'd3, 8'h5A, 8'h11, 8'h22, 1'b1, 1'b0, 1'b0);
    run_txn(2'b01, 8'd3, 8'h00, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
    run_txn(2'b11, 8'd9, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    run_txn(2'b10, 8'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    run_txn(2'b01, 8'h77, 8'h00, 8'h01, 8'h02, 1'b1, 1'b1, 1'b0);

    // Random traffic over a small index range so queries both hit and miss.
    for (int i = 0; i < 45; i++) begin
      run_txn(2'($urandom_range(0, 3)), 8'($urandom_range(0, 7)), 8'($urandom),
              8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);
    end
    run_txn(2'b10, 8'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Host keeps dataReceived high: bridge must park in DONE.
    run_txn(2'b00, 8'd5, 8'hC3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

    // Reset during WAIT aborts the QUERY with no strobe and no response.
    @(negedge clk);
    ctrl = 8'h01;
    din  = '0;
    din[15:8] = 8'd3;
    dr = 1'b1;
    k  = 0;
    while (!ev && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("abort_strobe_seen", 64'(ev), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    dr  = 1'b0;
    @(negedge clk);
    check_all_zero("abort");
    rst = 1'b0;
    model_reset();
    s0 = strobes;
    repeat (6) @(negedge clk);
    check("abort_no_tx", 64'(tx), 64'd0);
    check("abort_no_strobe", 64'(strobes - s0), 64'd0);

    // After reset: counters and sequence restart; run past the 15->0 wrap.
    for (int i = 0; i < 18; i++) begin
      run_txn(2'($urandom_range(0, 3)), 8'($urandom_range(0, 7)), 8'($urandom),
              8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);
    end
    run_txn(2'b10, 8'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
